// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the button conditioner
// Provides the 1 ms tick rate, a ms-to-cycles conversion and a counter width helper.
package debounce_pkg;
    localparam int TICK_HZ = 1000;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / TICK_HZ) * ms;
    endfunction

    // Width able to hold 0..max_val, never narrower than one bit
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel (synchroniser, debounce filter, press/release/long strobes)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tick           1 ms strobe from the shared prescaler
//   raw            raw button pin
//   clean          debounced level, 1 = pressed
//   press_pulse    1-cycle strobe on clean 0->1
//   release_pulse  1-cycle strobe on clean 1->0
//   long_pulse     1-cycle strobe once per press after LONG_MS of hold
module debounce_chan #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    import debounce_pkg::*;

    localparam int DW = cnt_w(DEBOUNCE_MS);
    localparam int HW = cnt_w(LONG_MS);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_MS - 1);
    // LONG_MS == 0 makes HOLD_MAX 0, so hold_cnt < HOLD_MAX never holds and long_pulse stays 0
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

    logic          s1;
    logic          s2;
    logic          p;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;

    always_comb begin
        p        = s2 ^ ACTIVE_LOW;
        hold_nxt = hold_cnt + HW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= ACTIVE_LOW;
            s2            <= ACTIVE_LOW;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            clean         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            s1            <= raw;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            // any cycle of agreement restarts the stability count
            if (p == clean) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt == DB_LAST) begin
                    clean         <= p;
                    db_cnt        <= '0;
                    press_pulse   <= p;
                    release_pulse <= !p;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
            // hold counter saturates at LONG_MS so only one long strobe per press
            if (!clean) begin
                hold_cnt <= '0;
            end else if (tick && hold_cnt < HOLD_MAX) begin
                hold_cnt   <= hold_nxt;
                long_pulse <= hold_nxt == HOLD_MAX;
            end
        end
    end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel button conditioner with a shared 1 ms tick prescaler
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   btn_in_raw         raw noisy button pins
//   btn_out_clean      debounced levels, active-high
//   btn_press_pulse    1-cycle strobes on debounced press
//   btn_release_pulse  1-cycle strobes on debounced release
//   btn_long_pulse     1-cycle strobes after LONG_MS of hold
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int CLK_FREQ    = 25_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in_raw,
    output logic [N_CH-1:0] btn_out_clean,
    output logic [N_CH-1:0] btn_press_pulse,
    output logic [N_CH-1:0] btn_release_pulse,
    output logic [N_CH-1:0] btn_long_pulse
);
    import debounce_pkg::*;

    localparam int TICK_CYCLES = ms_to_cycles(CLK_FREQ, 1);
    localparam int PW = cnt_w(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    always_comb tick = pre_cnt == PRE_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .ACTIVE_LOW (ACTIVE_LOW != 0)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .raw          (btn_in_raw[i]),
            .clean        (btn_out_clean[i]),
            .press_pulse  (btn_press_pulse[i]),
            .release_pulse(btn_release_pulse[i]),
            .long_pulse   (btn_long_pulse[i])
        );
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: scoreboard bench for debounce_multi (10 cycles/tick, 3 ms debounce, 8 ms long)
module tb_debounce_multi;
    typedef struct {
        int kind;
        int ch;
        int lo;
        int hi;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'hF;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] prev_clean = 4'h0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_cyc[3][4];
    ev_t        q[$];

    debounce_multi #(
        .N_CH(4), .CLK_FREQ(10_000), .DEBOUNCE_MS(3), .LONG_MS(8), .ACTIVE_LOW(1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .btn_in_raw       (raw),
        .btn_out_clean    (clean),
        .btn_press_pulse  (press),
        .btn_release_pulse(rel),
        .btn_long_pulse   (lng)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0 press, 1 release, 2 long
    task automatic pop(input int k, input int c);
        ev_t e;
        check($sformatf("strobe_expected k%0d ch%0d", k, c), q.size() > 0, 1);
        if (q.size() == 0) return;
        e = q.pop_front();
        check("event_kind_ch", k * 8 + c, e.kind * 8 + e.ch);
        check($sformatf("event_window k%0d ch%0d cyc%0d", k, c, cyc), cyc >= e.lo && cyc <= e.hi, 1);
        last_cyc[k][c] = cyc;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if ((clean ^ prev_clean) != 0 || press != 0 || rel != 0)
                check("strobe_vs_level", {press & ~clean, rel & clean, (clean ^ prev_clean) ^ (press | rel)}, 0);
            for (int c = 0; c < 4; c++) begin
                if (press[c]) pop(0, c);
                if (rel[c])   pop(1, c);
                if (lng[c])   pop(2, c);
            end
        end
        prev_clean = clean;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int k, input int c, input int lo, input int hi);
        q.push_back('{k, c, lo, hi});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, q.size(), 0);
    endtask

    initial begin
        int k;
        int p;
        int d1;
        // 1: reset with idle inputs, no strobes afterwards
        step(3);
        check("reset_outputs", {clean, press, rel, lng}, 0);
        rst_n = 1'b1;
        step(500);
        check("idle_after_reset", {clean, press, rel, lng}, 0);
        // 2: press and release on channel 0
        k = cyc;
        raw[0] = 1'b0;
        expect_ev(0, 0, k + 23, k + 32);
        drain("press0_seen", 40);
        check("clean0_high", clean, 4'b0001);
        k = cyc;
        raw[0] = 1'b1;
        expect_ev(1, 0, k + 23, k + 32);
        drain("release0_seen", 40);
        check("clean0_low", clean, 4'b0000);
        // 3: bouncing channel 1, short glitch on channel 2
        for (int i = 0; i < 8; i++) begin
            raw[1] = ~raw[1];
            step(15);
        end
        check("bounce_no_change", clean, 4'b0000);
        raw[2] = 1'b0;
        step(20);
        raw[2] = 1'b1;
        step(40);
        check("glitch2_no_change", clean, 4'b0000);
        k = cyc;
        raw[1] = 1'b0;
        expect_ev(0, 1, k + 23, k + 32);
        drain("press1_seen", 40);
        p = last_cyc[0][1];
        expect_ev(2, 1, p + 71, p + 80);
        drain("long1_seen", 100);
        k = cyc;
        raw[1] = 1'b1;
        expect_ev(1, 1, k + 23, k + 32);
        drain("release1_seen", 40);
        // 4: long press twice on channel 0
        k = cyc;
        raw[0] = 1'b0;
        expect_ev(0, 0, k + 23, k + 32);
        drain("press0b_seen", 40);
        p = last_cyc[0][0];
        expect_ev(2, 0, p + 71, p + 80);
        step(p + 200 - cyc);
        check("long0_once", q.size(), 0);
        d1 = last_cyc[2][0] - p;
        k = cyc;
        raw[0] = 1'b1;
        expect_ev(1, 0, k + 23, k + 32);
        drain("release0b_seen", 40);
        k = cyc;
        raw[0] = 1'b0;
        expect_ev(0, 0, k + 23, k + 32);
        drain("press0c_seen", 40);
        p = last_cyc[0][0];
        expect_ev(2, 0, p + 71, p + 80);
        step(p + 120 - cyc);
        check("long0_again", q.size(), 0);
        check("long_delay_repeat", last_cyc[2][0] - p, d1);
        k = cyc;
        raw[0] = 1'b1;
        expect_ev(1, 0, k + 23, k + 32);
        drain("release0c_seen", 40);
        // 5: simultaneous presses on channels 1 and 3
        k = cyc;
        raw[1] = 1'b0;
        raw[3] = 1'b0;
        expect_ev(0, 1, k + 23, k + 32);
        expect_ev(0, 3, k + 23, k + 32);
        drain("press13_seen", 40);
        check("press13_same_cycle", last_cyc[0][3], last_cyc[0][1]);
        check("clean13", clean, 4'b1010);
        k = cyc;
        raw[1] = 1'b1;
        raw[3] = 1'b1;
        expect_ev(1, 1, k + 23, k + 32);
        expect_ev(1, 3, k + 23, k + 32);
        drain("release13_seen", 40);
        // 6: reset during a long hold, button still held afterwards
        k = cyc;
        raw[0] = 1'b0;
        expect_ev(0, 0, k + 23, k + 32);
        drain("press0d_seen", 40);
        step(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {clean, press, rel, lng}, 0);
        step(3);
        rst_n = 1'b1;
        k = cyc;
        expect_ev(0, 0, k + 23, k + 32);
        drain("press0_after_reset", 40);
        p = last_cyc[0][0];
        expect_ev(2, 0, p + 71, p + 80);
        drain("long0_after_reset", 100);
        k = cyc;
        raw[0] = 1'b1;
        expect_ev(1, 0, k + 23, k + 32);
        drain("release0_after_reset", 40);
        step(50);
        check("final_quiet", {clean, press, rel, lng}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
